// File: rtl/alu32_arbiter.sv
// Two-requester round-robin front end for a shared combinational alu32.
// Holds the granted operands on the ALU for WAIT_CYCLES cycles, then returns the result.
module alu32_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_sel,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_sel,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_sel,
  input  logic [31:0] alu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_id,
  output logic        busy,
  output logic [15:0] done_count
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic        prio_q;
  logic [2:0]  cnt_q;
  logic [31:0] a_q, b_q;
  logic [2:0]  sel_q;
  logic        id_q;
  logic [31:0] rsp_data_q;
  logic        rsp_id_q;
  logic [15:0] done_count_q;

  logic gnt0, gnt1, accept, last_exec, rsp_hs;

  always_comb begin
    gnt0 = req0_valid & (~req1_valid | ~prio_q);
    gnt1 = req1_valid & (~req0_valid | prio_q);
    // Ready is masked during reset so nothing is granted in the reset cycle.
    req0_ready = (state_q == StIdle) & ~reset & gnt0;
    req1_ready = (state_q == StIdle) & ~reset & gnt1;
    accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    last_exec  = (state_q == StExec) && (cnt_q == 3'd0);
    rsp_hs     = (state_q == StResp) & rsp_ready;

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  if (last_exec) state_d = StResp;
      StResp:  if (rsp_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      prio_q       <= 1'b0;
      cnt_q        <= 3'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      sel_q        <= 3'd0;
      id_q         <= 1'b0;
      rsp_data_q   <= 32'd0;
      rsp_id_q     <= 1'b0;
      done_count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= req1_ready ? req1_a : req0_a;
        b_q   <= req1_ready ? req1_b : req0_b;
        sel_q <= req1_ready ? req1_sel : req0_sel;
        id_q  <= req1_ready;
        cnt_q <= 3'(WAIT_CYCLES - 1);
      end else if ((state_q == StExec) && (cnt_q != 3'd0)) begin
        cnt_q <= cnt_q - 3'd1;
      end
      if (last_exec) begin
        rsp_data_q <= alu_out;
        rsp_id_q   <= id_q;
      end
      if (rsp_hs) begin
        prio_q       <= ~rsp_id_q;
        done_count_q <= done_count_q + 16'd1;
      end
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_sel    = sel_q;
  assign rsp_valid  = (state_q == StResp);
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign busy       = (state_q != StIdle);
  assign done_count = done_count_q;

endmodule

// File: tb/tb_alu32_arbiter.sv
// Directed bench: one arbiter with WAIT_CYCLES=1 and one with WAIT_CYCLES=3,
// each driving a behavioural alu32 model.
module tb_alu32_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_v, r1_v, v1_0, v1_1, rsp_ready;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic [2:0]  r0_sel, r1_sel;

  logic        u0_r0_ready, u0_r1_ready, u0_rsp_valid, u0_rsp_id, u0_busy;
  logic [31:0] u0_alu_a, u0_alu_b, u0_alu_out, u0_rsp_data;
  logic [2:0]  u0_alu_sel;
  logic [15:0] u0_done;

  logic        u1_r0_ready, u1_r1_ready, u1_rsp_valid, u1_rsp_id, u1_busy;
  logic [31:0] u1_alu_a, u1_alu_b, u1_alu_out, u1_rsp_data;
  logic [2:0]  u1_alu_sel;
  logic [15:0] u1_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] sel);
    case (sel)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b011:  return a ^ b;
      3'b100:  return a - b;
      3'b101:  return $signed(a) >>> b[4:0];
      3'b110:  return a << b[4:0];
      default: return ~(a | b);
    endcase
  endfunction

  assign u0_alu_out = alu(u0_alu_a, u0_alu_b, u0_alu_sel);
  assign u1_alu_out = alu(u1_alu_a, u1_alu_b, u1_alu_sel);

  alu32_arbiter #(.WAIT_CYCLES(1)) u0 (
    .clk(clk), .reset(reset),
    .req0_valid(r0_v), .req0_ready(u0_r0_ready), .req0_a(r0_a), .req0_b(r0_b),
    .req0_sel(r0_sel),
    .req1_valid(r1_v), .req1_ready(u0_r1_ready), .req1_a(r1_a), .req1_b(r1_b),
    .req1_sel(r1_sel),
    .alu_a(u0_alu_a), .alu_b(u0_alu_b), .alu_sel(u0_alu_sel), .alu_out(u0_alu_out),
    .rsp_valid(u0_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(u0_rsp_data),
    .rsp_id(u0_rsp_id), .busy(u0_busy), .done_count(u0_done)
  );

  alu32_arbiter #(.WAIT_CYCLES(3)) u1 (
    .clk(clk), .reset(reset),
    .req0_valid(v1_0), .req0_ready(u1_r0_ready), .req0_a(r0_a), .req0_b(r0_b),
    .req0_sel(r0_sel),
    .req1_valid(v1_1), .req1_ready(u1_r1_ready), .req1_a(r1_a), .req1_b(r1_b),
    .req1_sel(r1_sel),
    .alu_a(u1_alu_a), .alu_b(u1_alu_b), .alu_sel(u1_alu_sel), .alu_out(u1_alu_out),
    .rsp_valid(u1_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(u1_rsp_data),
    .rsp_id(u1_rsp_id), .busy(u1_busy), .done_count(u1_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic        exp_id   [4];
  logic [31:0] exp_data [4];

  initial begin
    exp_id   = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_data = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF};

    reset = 1'b1; r0_v = 1'b0; r1_v = 1'b0; v1_0 = 1'b0; v1_1 = 1'b0; rsp_ready = 1'b0;
    r0_a = '0; r0_b = '0; r0_sel = '0; r1_a = '0; r1_b = '0; r1_sel = '0;
    tick(); tick();
    // Reset state, with a valid present to show ready stays low in the reset cycle.
    r0_v = 1'b1;
    #1;
    check("rst_busy", u0_busy, 0);
    check("rst_r0_ready", u0_r0_ready, 0);
    check("rst_r1_ready", u0_r1_ready, 0);
    check("rst_rsp_valid", u0_rsp_valid, 0);
    check("rst_rsp_data", u0_rsp_data, 0);
    check("rst_rsp_id", u0_rsp_id, 0);
    check("rst_alu_a", u0_alu_a, 0);
    check("rst_alu_b", u0_alu_b, 0);
    check("rst_alu_sel", u0_alu_sel, 0);
    check("rst_done", u0_done, 0);
    r0_v = 1'b0;
    tick();
    reset = 1'b0;

    // Single ADD from requester 0.
    tick();
    r0_v = 1'b1; r0_a = 32'd5; r0_b = 32'd3; r0_sel = 3'b010;
    #1;
    check("add_r0_ready", u0_r0_ready, 1);
    check("add_r1_ready", u0_r1_ready, 0);
    tick();
    r0_v = 1'b0;
    check("add_exec_busy", u0_busy, 1);
    check("add_exec_sel", u0_alu_sel, 3'b010);
    check("add_exec_a", u0_alu_a, 32'd5);
    check("add_exec_valid", u0_rsp_valid, 0);
    check("add_exec_ready", u0_r0_ready, 0);
    tick();
    check("add_rsp_valid", u0_rsp_valid, 1);
    check("add_rsp_data", u0_rsp_data, 32'd8);
    check("add_rsp_id", u0_rsp_id, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("add_after_valid", u0_rsp_valid, 0);
    check("add_after_busy", u0_busy, 0);
    check("add_done", u0_done, 1);

    // Fresh reset, then both requesters contend continuously.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_done", u0_done, 0);
    r0_a = 32'hFFFF_FFFF; r0_b = 32'hFFFF_FFFF; r0_sel = 3'b100;
    r1_a = 32'h0; r1_b = 32'h0; r1_sel = 3'b111;
    r0_v = 1'b1; r1_v = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_idle_r0_ready", u0_r0_ready, exp_id[i] == 1'b0);
      check("rr_idle_r1_ready", u0_r1_ready, exp_id[i] == 1'b1);
      tick();
      check("rr_exec_busy", u0_busy, 1);
      check("rr_exec_ready", {u0_r0_ready, u0_r1_ready}, 0);
      tick();
      check("rr_rsp_valid", u0_rsp_valid, 1);
      check("rr_rsp_ready", {u0_r0_ready, u0_r1_ready}, 0);
      check("rr_rsp_id", u0_rsp_id, exp_id[i]);
      check("rr_rsp_data", u0_rsp_data, exp_data[i]);
      tick();
    end
    r0_v = 1'b0; r1_v = 1'b0; rsp_ready = 1'b0;
    check("rr_done", u0_done, 4);

    // Backpressure: SL 7<<2 held in RESP for five cycles.
    r1_a = 32'd7; r1_b = 32'd2; r1_sel = 3'b110; r1_v = 1'b1;
    #1;
    check("bp_r1_ready", u0_r1_ready, 1);
    tick();
    r1_v = 1'b0;
    tick();
    r0_v = 1'b1; r1_v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid", u0_rsp_valid, 1);
      check("bp_data", u0_rsp_data, 32'h1C);
      check("bp_id", u0_rsp_id, 1);
      check("bp_alu_a", u0_alu_a, 32'd7);
      check("bp_alu_b", u0_alu_b, 32'd2);
      check("bp_alu_sel", u0_alu_sel, 3'b110);
      check("bp_ready", {u0_r0_ready, u0_r1_ready}, 0);
      check("bp_busy", u0_busy, 1);
      tick();
    end
    r0_v = 1'b0; r1_v = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_done", u0_done, 5);
    check("bp_idle", u0_busy, 0);

    // Reset in EXEC abandons the operation.
    r0_a = 32'h1234_5678; r0_b = 32'hFFFF_0000; r0_sel = 3'b011; r0_v = 1'b1;
    #1;
    check("ab_r0_ready", u0_r0_ready, 1);
    tick();
    r0_v = 1'b0;
    check("ab_exec_busy", u0_busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rsp_ready = 1'b1;
    check("ab_busy", u0_busy, 0);
    check("ab_valid", u0_rsp_valid, 0);
    check("ab_done", u0_done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ab_no_rsp", u0_rsp_valid, 0);
      check("ab_idle", u0_busy, 0);
    end
    rsp_ready = 1'b0;

    // WAIT_CYCLES=3 instance: AND from requester 1.
    r1_a = 32'hF0F0_F0F0; r1_b = 32'h0FF0_0FF0; r1_sel = 3'b000; v1_1 = 1'b1;
    #1;
    check("w3_r1_ready", u1_r1_ready, 1);
    tick();
    v1_1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("w3_exec_valid", u1_rsp_valid, 0);
      check("w3_exec_busy", u1_busy, 1);
      check("w3_exec_a", u1_alu_a, 32'hF0F0_F0F0);
      tick();
    end
    check("w3_rsp_valid", u1_rsp_valid, 1);
    check("w3_rsp_data", u1_rsp_data, 32'h00F0_00F0);
    check("w3_rsp_id", u1_rsp_id, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("w3_done", u1_done, 1);
    check("w3_idle", u1_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
